// File: rtl/fc_frame_packer_pkg.sv
// Shared types and constants for the FC frame packer.
//   state_t      : packer FSM states (LOAD / BURST / WAIT)
//   BYTE_SIZE    : width of one streamed int8 byte
//   WORD_SIZE    : width of one packed word toward the FC controller
//   frame_words(): number of 32-bit words in one frame
//                  (activations + weights + biases)
package fc_frame_packer_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    BURST = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam int BYTE_SIZE = 8;
  localparam int WORD_SIZE = 32;

  function automatic int frame_words(input int in_bytes, input int out_bytes);
    return (in_bytes + in_bytes * out_bytes + out_bytes) / 4;
  endfunction

endpackage

// File: rtl/fc_frame_packer_word_packer.sv
// fc_word_packer: collects four bytes into one little-endian word.
// The first byte lands in bits [7:0], the fourth in [31:24].
//   clk, rst   : clock, synchronous active-high reset
//   byte_valid : a byte is accepted this cycle
//   byte_data  : accepted byte
//   word       : assembled word, valid while word_done is high
//   word_idx   : index of the word being assembled (0..NUM_WORDS-1, wraps)
//   word_done  : the fourth byte of a word is being accepted this cycle
module fc_word_packer
  import fc_frame_packer_pkg::*;
#(
  parameter int NUM_WORDS = 11,
  parameter int IDX_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 byte_valid,
  input  logic [BYTE_SIZE-1:0] byte_data,
  output logic [WORD_SIZE-1:0] word,
  output logic [IDX_W-1:0]     word_idx,
  output logic                 word_done
);

  logic [1:0]               lane;
  logic [3*BYTE_SIZE-1:0]   partial;

  // The fourth byte bypasses the partial register so the full word is
  // available in the same cycle it completes.
  assign word_done = byte_valid && (lane == 2'd3);
  assign word      = {byte_data, partial};

  always_ff @(posedge clk) begin
    if (rst) begin
      lane     <= 2'd0;
      word_idx <= '0;
      partial  <= '0;
    end else if (byte_valid) begin
      lane <= lane + 2'd1;
      case (lane)
        2'd0:    partial[7:0]   <= byte_data;
        2'd1:    partial[15:8]  <= byte_data;
        2'd2:    partial[23:16] <= byte_data;
        default: ;
      endcase
      if (lane == 2'd3) begin
        word_idx <= (word_idx == IDX_W'(NUM_WORDS - 1)) ? '0 : word_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/fc_frame_packer.sv
// fc_frame_packer: loads one frame of int8 bytes (activations, weights,
// biases) into a word buffer, then bursts the words to the FC controller
// and waits for its result strobe before accepting the next frame.
//   clk, rst  : clock, synchronous active-high reset
//   s_valid   : upstream byte valid
//   s_data    : upstream byte
//   s_ready   : byte accepted when s_valid && s_ready
//   r_valid   : word strobe to the FC controller
//   in_data   : packed word to the FC controller (registered)
//   t_valid   : result-valid from the FC controller
//   busy      : high in BURST and WAIT
//   frame_cnt : completed frames, wrapping
//
// state | meaning
// LOAD  | accepting bytes into the frame buffer
// BURST | streaming buffer words 0..FRAME_WORDS-1, one per cycle
// WAIT  | frame sent, waiting for t_valid from the FC controller
module fc_frame_packer
  import fc_frame_packer_pkg::*;
#(
  parameter int IN_BYTES  = 8,
  parameter int OUT_BYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  input  logic [BYTE_SIZE-1:0] s_data,
  output logic                 s_ready,
  output logic                 r_valid,
  output logic [WORD_SIZE-1:0] in_data,
  input  logic                 t_valid,
  output logic                 busy,
  output logic [7:0]           frame_cnt
);

  localparam int FRAME_WORDS = frame_words(IN_BYTES, OUT_BYTES);
  localparam int IDX_W       = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  state_t                 state, next_state;
  logic [IDX_W-1:0]       burst_idx, next_burst_idx;
  logic                   byte_valid;
  logic [WORD_SIZE-1:0]   word;
  logic [IDX_W-1:0]       word_idx;
  logic                   word_done;
  logic                   frame_last;
  logic [WORD_SIZE-1:0]   rd_word;
  logic [WORD_SIZE-1:0]   frame_buf [FRAME_WORDS];

  // s_ready is only ever high in LOAD, so it also gates acceptance.
  assign byte_valid = s_valid && s_ready;
  assign frame_last = word_done && (word_idx == IDX_W'(FRAME_WORDS - 1));
  assign busy       = (state != LOAD);

  fc_word_packer #(
    .NUM_WORDS (FRAME_WORDS),
    .IDX_W     (IDX_W)
  ) u_word_packer (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_data  (s_data),
    .word       (word),
    .word_idx   (word_idx),
    .word_done  (word_done)
  );

  always_ff @(posedge clk) begin
    if (word_done) begin
      frame_buf[word_idx] <= word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      burst_idx <= '0;
    end else begin
      state     <= next_state;
      burst_idx <= next_burst_idx;
    end
  end

  always_comb begin
    next_state     = state;
    next_burst_idx = burst_idx;
    case (state)
      LOAD: begin
        if (frame_last) begin
          next_state     = BURST;
          next_burst_idx = '0;
        end
      end
      BURST: begin
        if (burst_idx == IDX_W'(FRAME_WORDS - 1)) begin
          next_state = WAIT;
        end else begin
          next_burst_idx = burst_idx + IDX_W'(1);
        end
      end
      WAIT: begin
        if (t_valid) begin
          next_state = LOAD;
        end
      end
      default: next_state = LOAD;
    endcase
  end

  // Word being written this cycle is forwarded so a one-word frame still
  // presents fresh data on its first burst cycle.
  always_comb begin
    rd_word = frame_buf[next_burst_idx];
    if (word_done && (word_idx == next_burst_idx)) begin
      rd_word = word;
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_ready   <= 1'b0;
      r_valid   <= 1'b0;
      in_data   <= '0;
      frame_cnt <= 8'd0;
    end else begin
      s_ready <= (next_state == LOAD);
      r_valid <= (next_state == BURST);
      in_data <= (next_state == BURST) ? rd_word : '0;
      if ((state == WAIT) && t_valid) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: doc/fc_frame_packer.md
FC_FRAME_PACKER -- requirements
Module: fc_frame_packer

Interface
REQ-001 Parameter IN_BYTES, default 8, number of int8 activation bytes per frame (multiple of 4).
REQ-002 Parameter OUT_BYTES, default 4, number of int8 output neurons per frame (multiple of 4).
REQ-003 Derived constant FRAME_WORDS SHALL equal (IN_BYTES + IN_BYTES*OUT_BYTES + OUT_BYTES)/4, which is 11 at the defaults.
REQ-004 clk  in  1  single clock; all logic is on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 s_valid  in  1  upstream byte valid.
REQ-007 s_data  in  8  upstream byte: activations, then weights, then biases.
REQ-008 s_ready  out  1  byte accepted when s_valid && s_ready.
REQ-009 r_valid  out  1  word strobe to the downstream FC controller.
REQ-010 in_data  out  32  packed word to the downstream FC controller.
REQ-011 t_valid  in  1  result-valid from the downstream FC controller.
REQ-012 busy  out  1  high in states BURST and WAIT.
REQ-013 frame_cnt  out  8  number of completed frames, wrapping.

Function
REQ-014 The FSM SHALL have exactly three states: LOAD, BURST and WAIT.
REQ-015 In LOAD, s_ready SHALL be 1, and each accepted byte SHALL be written to the frame buffer (FRAME_WORDS x 32 bits) at byte index 0..4*FRAME_WORDS-1.
REQ-016 Packing SHALL be little-endian: within each word, the 1st byte goes to bits [7:0], the 2nd to [15:8], the 3rd to [23:16] and the 4th to [31:24].
REQ-017 Acceptance of the final byte (index 4*FRAME_WORDS-1) in cycle N SHALL move the FSM to BURST, with s_ready=0 from cycle N+1.
REQ-018 In BURST, r_valid SHALL be 1 for exactly FRAME_WORDS consecutive cycles (N+1..N+FRAME_WORDS), presenting words 0..FRAME_WORDS-1 in order on in_data.
REQ-019 After the last burst word, the FSM SHALL enter WAIT with r_valid=0 and in_data=0.
REQ-020 In BURST and WAIT, s_ready SHALL be 0, and s_valid SHALL be ignored.
REQ-021 In WAIT, t_valid=1 in cycle M SHALL return the FSM to LOAD, with s_ready=1 in cycle M+1 and frame_cnt incremented in cycle M+1.
REQ-022 t_valid asserted in LOAD or BURST SHALL be ignored, with no state change and no count change.
REQ-023 frame_cnt SHALL wrap from 255 to 0.
REQ-024 Gaps in s_valid during LOAD SHALL be legal and SHALL NOT reset the byte index.
REQ-025 Outside BURST, r_valid SHALL be 0 and in_data SHALL be 0.
REQ-026 in_data SHALL be driven from a register, not combinationally from s_data.

Reset
REQ-027 While rst=1, the block SHALL hold: state=LOAD, byte index=0, s_ready=0, r_valid=0, in_data=0, busy=0, frame_cnt=0.
REQ-028 s_ready SHALL rise in the first cycle after rst deasserts.
REQ-029 rst asserted mid-LOAD, mid-BURST or in WAIT SHALL discard the partial frame or burst; no further r_valid SHALL occur until a complete new frame is loaded.
REQ-030 Frame buffer contents need not be cleared by rst.

Structure
REQ-031 A shared package SHALL hold the state enum (LOAD/BURST/WAIT), BYTE_SIZE=8, WORD_SIZE=32 and the FRAME_WORDS computation function.
REQ-032 One sub-module, fc_word_packer (4-byte little-endian assembler emitting word index and word-complete), SHALL be used; the FSM and buffer SHALL remain in the top module.

Verification
REQ-033 The bench SHALL cover: bytes 12,10,2A,B4,FF,1A,53,BD then 36 further bytes -> burst word0=B42A1012, word1=BD531AFF, r_valid high 11 consecutive cycles.
REQ-034 The bench SHALL cover: random s_valid gaps (about 50%) over a 44-byte frame -> identical burst contents to the gap-free case; s_ready=0 throughout BURST and WAIT.
REQ-035 The bench SHALL cover: t_valid pulsed during BURST, then again 3 cycles into WAIT -> only the second pulse returns the FSM to LOAD; frame_cnt 0->1.
REQ-036 The bench SHALL cover: rst pulsed after 20 bytes, then a full new frame -> no r_valid before the new frame completes; burst word0 equals the new frame's first 4 bytes.
REQ-037 The bench SHALL cover: 256 back-to-back frames, each with t_valid answered -> frame_cnt wraps to 0, and every burst matches a reference packing model.
REQ-038 The bench SHALL cover: the full chain with the downstream FC controller, driving the two known-answer frames -> results 0x80808080-saturated patterns matching the golden values.
